// File: rtl/cnn_top.sv
// cnn_top: fixed-weight 6x6 conv, ReLU, 2x2 max-pool and FC binary classifier
module cnn_top #(
  parameter logic signed [31:0] BIAS = -4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic prediction,
  output logic done
);
  typedef enum logic [2:0] {IDLE, CONV, POOL, FC, DONE} state_t;
  localparam logic signed [7:0] KERN [3] = '{-8'sd1, 8'sd0, 8'sd1};
  localparam logic signed [7:0] W [4] = '{8'sd1, -8'sd2, 8'sd1, 8'sd1};
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, idx_q, idx_d;
  logic signed [19:0] acc_q, acc_d, max_q, max_d;
  logic signed [19:0] feat_q [16];
  logic signed [19:0] feat_d [16];
  logic signed [19:0] pool_q [4];
  logic signed [19:0] pool_d [4];
  logic signed [31:0] score_q, score_d;
  logic pred_q, pred_d, done_q, done_d;
  logic [1:0] ki, kj;
  logic [7:0] pix;
  logic signed [19:0] pix_s, k_s, elem, mx;
  logic signed [31:0] p_s, w_s, sum;
  always_comb begin
    ki = cnt_q < 4'd3 ? 2'd0 : cnt_q < 4'd6 ? 2'd1 : 2'd2;
    kj = cnt_q inside {4'd0, 4'd3, 4'd6} ? 2'd0 : cnt_q inside {4'd1, 4'd4, 4'd7} ? 2'd1 : 2'd2;
    pix = 8'd6 * ({6'b0, idx_q[3:2]} + {6'b0, ki}) + {6'b0, idx_q[1:0]} + {6'b0, kj};
    pix_s = {12'b0, pix};
    k_s = 20'(KERN[kj]);
    elem = feat_q[{idx_q[1], cnt_q[1], idx_q[0], cnt_q[0]}];
    mx = cnt_q == 4'd0 ? elem : (elem > max_q ? elem : max_q);
    p_s = 32'(pool_q[cnt_q[1:0]]);
    w_s = 32'(W[cnt_q[1:0]]);
    sum = score_q + BIAS;
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    acc_d = acc_q;
    max_d = max_q;
    feat_d = feat_q;
    pool_d = pool_q;
    score_d = score_q;
    pred_d = pred_q;
    done_d = done_q;
    case (state_q)
      CONV: begin
        acc_d = acc_q + pix_s * k_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          feat_d[idx_q] = acc_q < 0 ? '0 : acc_q;
          acc_d = '0;
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
          state_d = idx_q == 4'd15 ? POOL : CONV;
        end
      end
      POOL: begin
        max_d = mx;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd3) begin
          pool_d[idx_q[1:0]] = mx;
          cnt_d = '0;
          idx_d = idx_q == 4'd3 ? '0 : idx_q + 4'd1;
          score_d = '0;
          state_d = idx_q == 4'd3 ? FC : POOL;
        end
      end
      FC: begin
        cnt_d = cnt_q + 4'd1;
        score_d = score_q + p_s * w_s;
        if (cnt_q == 4'd4) begin
          score_d = sum;
          pred_d = sum > 0;
          done_d = 1'b1;
          cnt_d = '0;
          state_d = DONE;
        end
      end
      default: begin
        if (start) begin
          state_d = CONV;
          done_d = 1'b0;
          cnt_d = '0;
          idx_d = '0;
          acc_d = '0;
          max_d = '0;
          score_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      max_q <= '0;
      feat_q <= '{default: '0};
      pool_q <= '{default: '0};
      score_q <= '0;
      pred_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      max_q <= max_d;
      feat_q <= feat_d;
      pool_q <= pool_d;
      score_q <= score_d;
      pred_q <= pred_d;
      done_q <= done_d;
    end
  end
  assign prediction = pred_q;
  assign done = done_q;
endmodule

// File: tb/tb_cnn_top.sv
// tb_cnn_top: directed table-driven bench running three BIAS variants in lockstep
module tb_cnn_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] dn, pr;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    int e;
    logic [2:0] done_e;
    logic chk_pred;
    logic [2:0] pred_e;
  } vec_t;
  vec_t tbl [7];
  always #5 clk = ~clk;
  cnn_top u_b4 (.clk(clk), .reset(reset), .start(start), .prediction(pr[0]), .done(dn[0]));
  cnn_top #(.BIAS(-6)) u_b6 (.clk(clk), .reset(reset), .start(start), .prediction(pr[1]), .done(dn[1]));
  cnn_top #(.BIAS(-5)) u_b5 (.clk(clk), .reset(reset), .start(start), .prediction(pr[2]), .done(dn[2]));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input int pa, input int pb, input logic hold, input logic [2:0] old_pred);
    start = 1'b1;
    for (int e = 1; e <= 182; e++) begin
      step();
      start = hold || e + 1 == pa || e + 1 == pb;
      if (e == 1 || e == 181) chk($sformatf("pred_hold@%0d", e), 32'(pr), 32'(old_pred));
      foreach (tbl[t]) begin
        if (tbl[t].e == e) begin
          chk($sformatf("done@%0d", e), 32'(dn), 32'(tbl[t].done_e));
          if (tbl[t].chk_pred) chk($sformatf("pred@%0d", e), 32'(pr), 32'(tbl[t].pred_e));
        end
      end
    end
  endtask
  initial begin
    int highs;
    tbl[0] = '{1, 3'b000, 1'b0, 3'b000};
    tbl[1] = '{2, 3'b000, 1'b0, 3'b000};
    tbl[2] = '{100, 3'b000, 1'b0, 3'b000};
    tbl[3] = '{161, 3'b000, 1'b0, 3'b000};
    tbl[4] = '{177, 3'b000, 1'b0, 3'b000};
    tbl[5] = '{181, 3'b000, 1'b0, 3'b000};
    tbl[6] = '{182, 3'b111, 1'b1, 3'b101};
    step();
    step();
    chk("reset_done", 32'(dn), 32'd0);
    chk("reset_pred", 32'(pr), 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("idle_done", 32'(dn), 32'd0);
    run(0, 0, 1'b0, 3'b000);
    step();
    chk("done_hold", 32'(dn), 32'b111);
    chk("pred_hold", 32'(pr), 32'b101);
    run(10, 100, 1'b0, 3'b101);
    start = 1'b1;
    for (int e = 1; e < 50; e++) begin
      step();
      start = 1'b0;
    end
    reset = 1'b1;
    step();
    chk("abort_done", 32'(dn), 32'd0);
    chk("abort_pred", 32'(pr), 32'd0);
    reset = 1'b0;
    highs = 0;
    for (int e = 0; e < 200; e++) begin
      step();
      if (dn != 3'b000) highs++;
    end
    chk("abort_no_done", 32'(highs), 32'd0);
    run(0, 0, 1'b0, 3'b000);
    run(0, 0, 1'b1, 3'b101);
    step();
    chk("b2b_done@183", 32'(dn), 32'd0);
    highs = 0;
    for (int e = 184; e <= 364; e++) begin
      step();
      if (e == 363) chk("b2b_done@363", 32'(dn), 32'd0);
      if (dn[0]) highs++;
    end
    chk("b2b_done@364", 32'(dn), 32'b111);
    chk("b2b_pred@364", 32'(pr), 32'b101);
    chk("b2b_highs", 32'(highs), 32'd1);
    start = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cnn_top.md
CNN_TOP -- requirements
Module: cnn_top

Interface
REQ-001 The block SHALL have parameter BIAS, default -4, a signed 32-bit bias added to the fully-connected score.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a run request, sampled on the rising edge.
REQ-005 The block SHALL have port prediction, output, 1 bit: the binary class result, registered.
REQ-006 The block SHALL have port done, output, 1 bit: high while a valid result is held, registered.

Function
REQ-007 The block SHALL hold a fixed 6x6 image ROM of unsigned 8-bit pixels, where pixel(r,c) = 6*r + c, for r,c in 0..5.
REQ-008 The block SHALL hold a fixed 3x3 signed 8-bit kernel with every row equal to [-1, 0, +1].
REQ-009 The block SHALL hold fixed signed 8-bit FC weights W[0..3] = [1, -2, 1, 1], indexed row-major over the pooled map.
REQ-010 Convolution SHALL be valid-mode with stride 1, producing a 4x4 map.
- conv(i,j) = sum over kernel taps of pixel(i+ki, j+kj) * K(ki,kj).
- Accumulator: signed 20 bits.
REQ-011 ReLU SHALL clamp negative conv results to 0 and store each as a 20-bit value in a 16-entry feature register array.
REQ-012 2x2 max-pool with stride 2 SHALL produce a 2x2 map P[0..3], row-major.
REQ-013 Score SHALL be computed as sum(P[k] * W[k]) + BIAS in a signed 32-bit accumulator.
- prediction = 1 when score > 0 (strict); otherwise 0.
REQ-014 The FSM SHALL have the states IDLE, CONV, POOL, FC and DONE.
REQ-015 IDLE SHALL go to CONV on the edge where start=1; the accumulators and indices are cleared on that edge.
REQ-016 CONV SHALL take 10 cycles per output (9 sequential MAC cycles, then 1 ReLU/write cycle).
- Outputs are processed row-major.
- Total: 160 cycles, then go to POOL.
REQ-017 POOL SHALL take 4 cycles per output (one compare per cycle, running max seeded with the first element, write on the 4th).
- Total: 16 cycles, then go to FC.
REQ-018 FC SHALL take 4 MAC cycles plus 1 bias/compare cycle.
- The 5th edge loads prediction, sets done=1 and enters DONE.
REQ-019 Latency SHALL be fixed: counting the start-sampling edge as edge 1, done rises at edge 182.
REQ-020 start SHALL be ignored in CONV, POOL and FC; a run's timing and result are unaffected by start pulses.
REQ-021 In DONE, done and prediction SHALL hold until the next start or reset.
- start=1 in DONE: clear done on that edge and enter CONV, as from IDLE.
- prediction keeps its old value until overwritten at the end of the new run.
REQ-022 A start held high continuously SHALL cause back-to-back runs, with done high for exactly one cycle between them.

Reset
REQ-023 While reset=1 at a rising edge, the block SHALL enter IDLE and clear done, prediction, all indices, accumulators and feature/pooled registers to 0.
- reset takes priority over start.
REQ-024 Reset asserted mid-run SHALL abort the run; done does not assert for that run.
REQ-025 After reset deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-026 Default BIAS, reset 2 cycles, 1-cycle start pulse -> every conv value = 6, every P = 6, score = 2.
- Required: done rises at edge 182; prediction=1.
REQ-027 BIAS=-6, same stimulus -> score = 0 -> prediction=0, done at edge 182 (strict > boundary).
REQ-028 BIAS=-5 -> score = 1 -> prediction=1.
REQ-029 Extra start pulses at edges 10 and 100 of a run -> done still at edge 182, prediction=1, no restart.
REQ-030 Reset asserted at edge 50 of a run, then a new start -> done stays 0 through the abort; done rises 182 edges after the new start.
REQ-031 start asserted in DONE -> done=0 on the next edge; second run completes 182 edges later with prediction=1.
